// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, control and decode-side signals of the fetch stage
// master = fetch_unit side, slave = memory/control/decode side
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_pc_plus4;
  logic                  misalign_err;
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, misalign_err,
    input  imem_rdata, redirect_valid, redirect_pc, halt_req, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, misalign_err,
    output imem_rdata, redirect_valid, redirect_pc, halt_req, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush
// ports: clk, rst_n (sync, active-low), push/din, pop/dout, flush, empty, count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int           DEPTH   = 2,
  parameter fetch_entry_t RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic w_pop, w_full;
  assign empty  = r_cnt == '0;
  assign w_full = r_cnt == (PW+1)'(DEPTH);
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];
  assign count  = r_cnt;
  // entries reset to RST_VAL so the idle head shows a NOP at the reset PC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      assert (!(push && w_full));
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 1-cycle-latency imem reads into a FIFO feeding decode
// ports: clk, rst_n (sync, active-low), bus (fetch_unit_if.master):
//   imem_req/imem_addr/imem_rdata, redirect_valid/redirect_pc, halt_req,
//   out_valid/out_ready/out_instr/out_pc/out_pc_plus4, misalign_err (sticky)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 2;
  localparam fetch_entry_t RST_ENTRY = '{pc: XLEN'(RESET_PC), instr: NOP_INSTR};
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_pc, r_req_pc;
  logic r_inflight, r_misalign;
  logic w_req, w_pop, w_push, w_empty, w_redir;
  logic [$clog2(DEPTH):0] w_count;
  fetch_entry_t w_din, w_head;
  assign w_redir       = bus.redirect_valid;
  assign bus.out_valid = !w_empty && !w_redir;
  assign w_pop         = bus.out_valid && bus.out_ready;
  // a returning word is dropped if a redirect lands in the same cycle
  assign w_push        = r_inflight && !w_redir;
  assign w_din         = '{pc: XLEN'(r_req_pc), instr: XLEN'(bus.imem_rdata)};
  always_comb begin
    w_next = w_redir || r_state == S_BOOT ? S_RUN
           : r_state == S_RUN && bus.halt_req ? S_HALT : r_state;
    // credit: FIFO occupancy plus the word in flight must leave room after this cycle's pop
    w_req  = r_state == S_RUN && !w_redir && !bus.halt_req &&
             (CW'(w_count) + CW'(r_inflight) < CW'(DEPTH) + CW'(w_pop));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_req;
      r_misalign <= r_misalign || (w_redir && |bus.redirect_pc[1:0]);
      if (w_req) r_req_pc <= r_pc;
      r_pc <= w_redir ? {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00}
            : w_req ? r_pc + ADDR_WIDTH'(4) : r_pc;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .RST_VAL(RST_ENTRY)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redir),
    .din   (w_din),
    .dout  (w_head),
    .empty (w_empty),
    .count (w_count)
  );
  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_pc;
  assign bus.out_instr    = w_head.instr[DATA_WIDTH-1:0];
  assign bus.out_pc       = w_head.pc[ADDR_WIDTH-1:0];
  assign bus.out_pc_plus4 = bus.out_pc + ADDR_WIDTH'(4);
  assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a stream-level model
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
  endfunction
  // memory answers one cycle after a request, garbage otherwise
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? word(bus.imem_addr) : $urandom();
  // model: m_outst = words requested but not yet consumed, m_infl = requested last cycle
  logic [31:0] m_fetch, m_out, hold_pc, hold_instr;
  int m_outst, m_infl;
  bit m_boot, m_halt, m_mis, stalled;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask
  task automatic monitor();
    int buffered;
    logic exp_valid, pop, exp_req;
    if (!rst_n) begin
      m_fetch = '0; m_out = '0; m_outst = 0; m_infl = 0;
      m_boot = 1; m_halt = 0; m_mis = 0; stalled = 0;
      return;
    end
    buffered  = m_outst - m_infl;
    exp_valid = !bus.redirect_valid && buffered > 0;
    pop       = exp_valid && bus.out_ready;
    exp_req   = !m_boot && !m_halt && !bus.redirect_valid && !bus.halt_req && (m_outst - int'(pop) < DEPTH);
    check_b("m_out_valid", bus.out_valid, exp_valid);
    check_b("m_imem_req", bus.imem_req, exp_req);
    check_b("m_misalign", bus.misalign_err, m_mis);
    if (stalled && !bus.redirect_valid) begin
      check("m_hold_pc", bus.out_pc, hold_pc);
      check("m_hold_instr", bus.out_instr, hold_instr);
    end
    if (exp_req) begin
      check("m_imem_addr", bus.imem_addr, m_fetch);
      m_fetch = m_fetch + 32'd4;
    end
    if (pop) begin
      check("m_out_pc", bus.out_pc, m_out);
      check("m_out_instr", bus.out_instr, word(m_out));
      check("m_out_pc_plus4", bus.out_pc_plus4, m_out + 32'd4);
      m_out = m_out + 32'd4;
    end
    stalled    = exp_valid && !bus.out_ready;
    hold_pc    = bus.out_pc;
    hold_instr = bus.out_instr;
    m_outst    = m_outst + int'(exp_req) - int'(pop);
    m_infl     = int'(exp_req);
    if (bus.redirect_valid) begin
      m_fetch = {bus.redirect_pc[31:2], 2'b00};
      m_out   = m_fetch;
      m_outst = 0; m_infl = 0; m_halt = 0;
      if (bus.redirect_pc[1:0] != 2'b00) m_mis = 1;
    end else if (bus.halt_req && !m_boot) m_halt = 1;
    m_boot = 0;
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect_to(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    #1;
    check_b("redir_out_valid", bus.out_valid, 1'b0);
    check_b("redir_imem_req", bus.imem_req, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check_b("tgt_imem_req", bus.imem_req, 1'b1);
    check("tgt_imem_addr", bus.imem_addr, {tgt[31:2], 2'b00});
    tick();
    check_b("tgt_gap_valid", bus.out_valid, 1'b0);
    tick();
    check_b("tgt_out_valid", bus.out_valid, 1'b1);
    check("tgt_out_pc", bus.out_pc, {tgt[31:2], 2'b00});
  endtask
  initial begin
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.halt_req = 1'b0;
    @(posedge clk); #1;
    tick();
    check_b("rst_out_valid", bus.out_valid, 1'b0);
    check_b("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_out_instr", bus.out_instr, NOP_INSTR);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check_b("rst_misalign", bus.misalign_err, 1'b0);
    rst_n = 1'b1; bus.out_ready = 1'b1; #1;
    check_b("boot_imem_req", bus.imem_req, 1'b0);
    tick();
    check_b("c1_imem_req", bus.imem_req, 1'b1);
    check("c1_imem_addr", bus.imem_addr, 32'h0);
    check_b("c1_out_valid", bus.out_valid, 1'b0);
    tick();
    check("c2_imem_addr", bus.imem_addr, 32'h4);
    check_b("c2_out_valid", bus.out_valid, 1'b0);
    tick();
    check_b("c3_out_valid", bus.out_valid, 1'b1);
    check("c3_out_pc", bus.out_pc, 32'h0);
    check("c3_out_pc_plus4", bus.out_pc_plus4, 32'h4);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_b("stream_valid", bus.out_valid, 1'b1);
      check("stream_pc", bus.out_pc, 32'(4 * k));
    end
    redirect_to(32'h100);
    tick();
    redirect_to(32'h102);
    check_b("misalign_set", bus.misalign_err, 1'b1);
    redirect_to(32'hFFFF_FFF8);
    tick();
    check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.out_pc_plus4, 32'h0);
    tick();
    check("wrap_next_pc", bus.out_pc, 32'h0);
    check_b("misalign_sticky", bus.misalign_err, 1'b1);
    bus.halt_req = 1'b1; #1;
    check_b("halt_imem_req", bus.imem_req, 1'b0);
    tick();
    bus.halt_req = 1'b0;
    repeat (4) begin
      tick();
      check_b("halted_imem_req", bus.imem_req, 1'b0);
    end
    check_b("halt_drained", bus.out_valid, 1'b0);
    redirect_to(32'h200);
    bus.out_ready = 1'b0; #1;
    repeat (5) begin
      tick();
      check_b("stall_valid", bus.out_valid, 1'b1);
      check("stall_pc", bus.out_pc, 32'h200);
    end
    check_b("stall_imem_req", bus.imem_req, 1'b0);
    bus.out_ready = 1'b1; #1;
    tick();
    check("release_pc1", bus.out_pc, 32'h204);
    tick();
    check("release_pc2", bus.out_pc, 32'h208);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    check_b("mid_rst_valid", bus.out_valid, 1'b0);
    check_b("mid_rst_req", bus.imem_req, 1'b0);
    check("mid_rst_instr", bus.out_instr, NOP_INSTR);
    check("mid_rst_pc", bus.out_pc, 32'h0);
    check_b("mid_rst_misalign", bus.misalign_err, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check_b("restart_req", bus.imem_req, 1'b1);
    check("restart_addr", bus.imem_addr, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      bus.out_ready      = $urandom_range(0, 9) < 7;
      bus.redirect_valid = $urandom_range(0, 99) < 4;
      bus.redirect_pc    = $urandom_range(0, 9) == 0 ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      bus.halt_req       = $urandom_range(0, 99) < 3;
      rst_n              = $urandom_range(0, 499) != 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
